stopwatch_cu: RTL

Stopwatch control-and-count stage. Consumes the single-cycle rising-edge pulses from the debounced button stages: one pulse for run/stop and one for clear. It runs a run/stop/clear state machine and keeps the elapsed time as centiseconds, seconds, minutes and hours. The outputs feed the FND/display multiplexer directly.

---
 rtl/stopwatch_cu.sv | 121 ++++++++++++
 1 files changed

// File: rtl/stopwatch_cu.sv
// Stopwatch control-and-count stage.
// Takes single-cycle run/stop and clear pulses from the debounced button
// stages, runs the STOP/RUN/CLEAR state machine and keeps elapsed time as
// centiseconds, seconds, minutes and hours for the display multiplexer.
module stopwatch_cu #(
  parameter int F_COUNT  = 1_000_000,  // clk cycles per 1/100 s tick
  parameter int MSEC_MAX = 100,
  parameter int SEC_MAX  = 60,
  parameter int MIN_MAX  = 60,
  parameter int HOUR_MAX = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_run_stop,
  input  logic       i_btn_clear,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_run
);

  // A one-cycle-per-tick configuration still needs a 1-bit prescaler.
  localparam int PRE_W = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(F_COUNT - 1);
  localparam logic [6:0]       MSEC_LAST = 7'(MSEC_MAX - 1);
  localparam logic [5:0]       SEC_LAST  = 6'(SEC_MAX - 1);
  localparam logic [5:0]       MIN_LAST  = 6'(MIN_MAX - 1);
  localparam logic [4:0]       HOUR_LAST = 5'(HOUR_MAX - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  state_t           r_state;
  logic [PRE_W-1:0] r_pre;
  logic [6:0]       r_msec;
  logic [5:0]       r_sec;
  logic [5:0]       r_min;
  logic [4:0]       r_hour;

  logic w_running;
  logic w_clearing;
  logic w_tick;
  logic w_msec_wrap;
  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_hour_wrap;

  assign w_running   = (r_state == ST_RUN);
  assign w_clearing  = (r_state == ST_CLEAR);
  assign w_tick      = w_running && (r_pre == PRE_LAST);
  assign w_msec_wrap = (r_msec == MSEC_LAST);
  assign w_sec_wrap  = (r_sec  == SEC_LAST);
  assign w_min_wrap  = (r_min  == MIN_LAST);
  assign w_hour_wrap = (r_hour == HOUR_LAST);

  // Run/stop/clear state machine; run_stop has priority over clear in STOP.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values and simulation matches hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_STOP;
    end else begin
      case (r_state)
        ST_STOP: begin
          if (i_btn_run_stop)   r_state <= ST_RUN;
          else if (i_btn_clear) r_state <= ST_CLEAR;
          else                  r_state <= ST_STOP;
        end
        ST_RUN: begin
          if (i_btn_run_stop) r_state <= ST_STOP;
          else                r_state <= ST_RUN;
        end
        ST_CLEAR: r_state <= ST_STOP;   // pulses seen here are dropped
        default:  r_state <= ST_STOP;   // illegal encoding recovers
      endcase
    end
  end

  // Tick prescaler: counts only in RUN, holds in STOP to keep the tick phase.
  always_ff @(posedge clk) begin
    if (rst || w_clearing) begin
      r_pre <= '0;
    end else if (w_running) begin
      if (r_pre == PRE_LAST) r_pre <= '0;
      else                   r_pre <= r_pre + 1'b1;
    end
  end

  // Time cascade: each field advances only when every lower field wraps.
  always_ff @(posedge clk) begin
    if (rst || w_clearing) begin
      r_msec <= '0;
      r_sec  <= '0;
      r_min  <= '0;
      r_hour <= '0;
    end else if (w_tick) begin
      r_msec <= w_msec_wrap ? 7'd0 : r_msec + 7'd1;
      if (w_msec_wrap) begin
        r_sec <= w_sec_wrap ? 6'd0 : r_sec + 6'd1;
        if (w_sec_wrap) begin
          r_min <= w_min_wrap ? 6'd0 : r_min + 6'd1;
          if (w_min_wrap) begin
            r_hour <= w_hour_wrap ? 5'd0 : r_hour + 5'd1;
          end
        end
      end
    end
  end

  assign o_msec = r_msec;
  assign o_sec  = r_sec;
  assign o_min  = r_min;
  assign o_hour = r_hour;
  assign o_run  = w_running;

endmodule
